rect_sequencer: RTL
===================

RECT_SEQUENCER -- requirements
Module: rect_sequencer

Interface
REQ-001 Parameter FRAMES_PER_RECT, default 60, means frames each rectangle stays displayed; legal range 2..255.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, means the LFSR value loaded at reset; it SHALL be nonzero.
REQ-003 clk  input  1  the single block clock, shared with the sync generator.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  high: run the rectangle sequence; low: stop and blank.
REQ-006 frame_tick  input  1  one-clk pulse marking the frame boundary (line counter wrap), synchronous to clk.
REQ-007 pixel  input  10  current pixel counter value.
REQ-008 line  input  10  current line counter value.
REQ-009 visible  input  1  high when pixel/line lie in the visible area.
REQ-010 rect_x0, rect_x1  output  10 each  active rectangle column bounds, inclusive, x0 < x1 < 640.
REQ-011 rect_y0, rect_y1  output  10 each  active rectangle row bounds, inclusive, y0 < y1 < 480.
REQ-012 rect_color  output  2  colour index of the active rectangle.
REQ-013 rect_valid  output  1  high while a committed rectangle is displayed.
REQ-014 in_rect  output  1  registered; high when the current pixel is inside the active rectangle.
REQ-015 rect_count  output  8  number of commits since reset, wrapping 255->0.

Function
REQ-016 FSM states: IDLE, GEN, HOLD; frame counter frame_cnt is 8 bits; shadow registers sx0/sx1/sy0/sy1/scol plus a shadow_ready flag.
REQ-017 LFSR: 16-bit Galois, right shift, XOR mask 16'hB400 when shifted-out bit is 1; it advances once per clk only in GEN.
REQ-018 GEN draws four candidates in order xa, xb, ya, yb; each candidate = lfsr[9:0] sampled in that cycle, at most one candidate per clk.
REQ-019 Reject and redraw next clk if an x candidate >= 640, a y candidate >= 480, or xb == xa, or yb == ya.
REQ-020 On accepting xb: sx0 = min(xa,xb), sx1 = max(xa,xb); on accepting yb: sy0/sy1 likewise, scol = lfsr[15:14], shadow_ready = 1, go to HOLD.
REQ-021 frame_cnt increments on every frame_tick in GEN and HOLD, saturating at 255.
REQ-022 Commit happens when frame_tick arrives with shadow_ready = 1 and frame_cnt >= FRAMES_PER_RECT-1.
REQ-023 Commit actions: active bounds and colour = shadow, rect_valid = 1, rect_count++, frame_cnt = 0, shadow_ready = 0, state = GEN.
REQ-024 If frame_tick arrives with frame_cnt >= FRAMES_PER_RECT-1 and shadow_ready = 0, do not commit; the next qualifying tick commits.
REQ-025 IDLE -> GEN when enable = 1; on entry frame_cnt = FRAMES_PER_RECT-1, so the first commit occurs on the first frame_tick after shadow_ready.
REQ-026 enable = 0 in any state: go to IDLE next clk and clear shadow_ready; rect_valid clears on the next frame_tick (no mid-frame tear).
REQ-027 Active rectangle registers change only on a commit frame_tick, never mid-frame.
REQ-028 in_rect(t+1) = visible & rect_valid & x0<=pixel<=x1 & y0<=line<=y1, evaluated at t (one clk latency).
REQ-029 All comparisons are unsigned 10-bit.

Reset
REQ-030 rst SHALL asynchronously force: state IDLE, lfsr = LFSR_SEED, frame_cnt = 0, shadow_ready = 0, every output and shadow register = 0.
REQ-031 rst asserted mid-GEN or mid-HOLD abandons the sequence; after release, behaviour is identical to power-up.

Structure
REQ-032 Shared package torso_pkg holds H_VISIBLE = 640, V_VISIBLE = 480, LFSR_MASK = 16'hB400, and the FSM state enum.
REQ-033 The LFSR is the single sub-module, rect_lfsr, with ports clk, rst, advance, value[15:0] and a seed parameter.

Verification
REQ-034 Reset release, enable = 0 -> all outputs 0, lfsr = 16'hACE1; first GEN advance yields 16'hE270.
REQ-035 FRAMES_PER_RECT = 2, enable = 1, a frame_tick every 1000 clks -> first commit on the first tick; later commits every 2 ticks; rect_count 1,2,3; bounds satisfy x0<x1<640 and y0<y1<480.
REQ-036 Force active x0 = 100, x1 = 200, y0 = 50, y1 = 60 -> in_rect high one clk after pixel = 100 and pixel = 200 (line 55); low after pixel = 99 and pixel = 201; low whenever visible = 0.
REQ-037 frame_tick in GEN with frame_cnt >= FRAMES_PER_RECT-1 and shadow_ready = 0 -> no commit, rect_count unchanged; commit at the next tick.
REQ-038 enable dropped mid-HOLD -> state IDLE next clk; rect_valid stays 1 until the next frame_tick, then 0.
REQ-039 rst pulsed for 3 clks mid-HOLD -> outputs 0 asynchronously; after release the sequence repeats the power-up rectangle values exactly.

Source files
------------

// File: rtl/torso_pkg.sv
// rtl/torso_pkg.sv - shared constants, FSM encodings and LFSR step for the rectangle sequencer
package torso_pkg;

    localparam logic [9:0]  H_VISIBLE = 10'd640;
    localparam logic [9:0]  V_VISIBLE = 10'd480;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

    // Order in which the four coordinate candidates are drawn.
    typedef enum logic [1:0] {
        DRAW_XA = 2'd0,
        DRAW_XB = 2'd1,
        DRAW_YA = 2'd2,
        DRAW_YB = 2'd3
    } draw_stage_e;

    // Galois right shift: the bit falling off the bottom folds the mask back in.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/rect_lfsr.sv
// rtl/rect_lfsr.sv - 16-bit Galois LFSR that steps only when advance is high
module rect_lfsr
    import torso_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= SEED;
        end else if (advance) begin
            value_q <= lfsr_step(value_q);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/rect_sequencer.sv
// rtl/rect_sequencer.sv - draws random rectangles into shadow registers and commits them on frame boundaries
module rect_sequencer
    import torso_pkg::*;
#(
    parameter int unsigned FRAMES_PER_RECT = 60,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [9:0] pixel,
    input  logic [9:0] line,
    input  logic       visible,
    output logic [9:0] rect_x0,
    output logic [9:0] rect_x1,
    output logic [9:0] rect_y0,
    output logic [9:0] rect_y1,
    output logic [1:0] rect_color,
    output logic       rect_valid,
    output logic       in_rect,
    output logic [7:0] rect_count
);

    localparam logic [7:0] FPR_LAST = 8'(FRAMES_PER_RECT - 1);

    seq_state_e  state_q;
    draw_stage_e stage_q;
    logic [7:0]  frame_cnt_q;
    logic [9:0]  xa_q, ya_q;
    logic [9:0]  sx0_q, sx1_q, sy0_q, sy1_q;
    logic [1:0]  scol_q;
    logic        shadow_ready_q;
    logic [9:0]  rect_x0_q, rect_x1_q, rect_y0_q, rect_y1_q;
    logic [1:0]  rect_color_q;
    logic        rect_valid_q;
    logic [7:0]  rect_count_q;
    logic        in_rect_q;

    logic [15:0] lfsr_value;
    logic        lfsr_advance;
    logic [9:0]  cand;
    logic        cand_ok;
    logic [9:0]  cand_lo, cand_hi;
    logic [7:0]  frame_cnt_d;
    logic        commit_d;
    logic        in_rect_d;
    logic        unused_lfsr_bits;

    // The generator only consumes randomness while actively drawing.
    assign lfsr_advance = enable && (state_q == GEN);

    rect_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (lfsr_advance),
        .value   (lfsr_value)
    );

    assign cand             = lfsr_value[9:0];
    assign unused_lfsr_bits = ^lfsr_value[13:10];

    always_comb begin
        cand_ok = 1'b0;
        cand_lo = cand;
        cand_hi = cand;
        case (stage_q)
            DRAW_XA: cand_ok = (cand < H_VISIBLE);
            DRAW_XB: begin
                cand_ok = (cand < H_VISIBLE) && (cand != xa_q);
                cand_lo = (cand < xa_q) ? cand : xa_q;
                cand_hi = (cand < xa_q) ? xa_q : cand;
            end
            DRAW_YA: cand_ok = (cand < V_VISIBLE);
            DRAW_YB: begin
                cand_ok = (cand < V_VISIBLE) && (cand != ya_q);
                cand_lo = (cand < ya_q) ? cand : ya_q;
                cand_hi = (cand < ya_q) ? ya_q : cand;
            end
            default: cand_ok = 1'b0;
        endcase
    end

    assign frame_cnt_d = (frame_cnt_q == 8'hFF) ? 8'hFF : frame_cnt_q + 8'd1;
    assign commit_d    = frame_tick && shadow_ready_q && (frame_cnt_q >= FPR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            stage_q        <= DRAW_XA;
            frame_cnt_q    <= 8'd0;
            xa_q           <= 10'd0;
            ya_q           <= 10'd0;
            sx0_q          <= 10'd0;
            sx1_q          <= 10'd0;
            sy0_q          <= 10'd0;
            sy1_q          <= 10'd0;
            scol_q         <= 2'd0;
            shadow_ready_q <= 1'b0;
            rect_x0_q      <= 10'd0;
            rect_x1_q      <= 10'd0;
            rect_y0_q      <= 10'd0;
            rect_y1_q      <= 10'd0;
            rect_color_q   <= 2'd0;
            rect_valid_q   <= 1'b0;
            rect_count_q   <= 8'd0;
        end else if (!enable) begin
            // Blanking waits for a frame boundary so the picture never tears.
            state_q        <= IDLE;
            stage_q        <= DRAW_XA;
            shadow_ready_q <= 1'b0;
            if (frame_tick) begin
                rect_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= GEN;
                    stage_q     <= DRAW_XA;
                    frame_cnt_q <= FPR_LAST;
                    if (frame_tick) begin
                        rect_valid_q <= 1'b0;
                    end
                end
                GEN: begin
                    if (frame_tick) begin
                        frame_cnt_q <= frame_cnt_d;
                    end
                    if (cand_ok) begin
                        case (stage_q)
                            DRAW_XA: begin
                                xa_q    <= cand;
                                stage_q <= DRAW_XB;
                            end
                            DRAW_XB: begin
                                sx0_q   <= cand_lo;
                                sx1_q   <= cand_hi;
                                stage_q <= DRAW_YA;
                            end
                            DRAW_YA: begin
                                ya_q    <= cand;
                                stage_q <= DRAW_YB;
                            end
                            default: begin
                                sy0_q          <= cand_lo;
                                sy1_q          <= cand_hi;
                                scol_q         <= lfsr_value[15:14];
                                shadow_ready_q <= 1'b1;
                                stage_q        <= DRAW_XA;
                                state_q        <= HOLD;
                            end
                        endcase
                    end
                end
                HOLD: begin
                    if (commit_d) begin
                        rect_x0_q      <= sx0_q;
                        rect_x1_q      <= sx1_q;
                        rect_y0_q      <= sy0_q;
                        rect_y1_q      <= sy1_q;
                        rect_color_q   <= scol_q;
                        rect_valid_q   <= 1'b1;
                        rect_count_q   <= rect_count_q + 8'd1;
                        frame_cnt_q    <= 8'd0;
                        shadow_ready_q <= 1'b0;
                        stage_q        <= DRAW_XA;
                        state_q        <= GEN;
                    end else if (frame_tick) begin
                        frame_cnt_q <= frame_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_rect_d = visible && rect_valid_q
                    && (pixel >= rect_x0_q) && (pixel <= rect_x1_q)
                    && (line  >= rect_y0_q) && (line  <= rect_y1_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_rect_q <= 1'b0;
        end else begin
            in_rect_q <= in_rect_d;
        end
    end

    assign rect_x0    = rect_x0_q;
    assign rect_x1    = rect_x1_q;
    assign rect_y0    = rect_y0_q;
    assign rect_y1    = rect_y1_q;
    assign rect_color = rect_color_q;
    assign rect_valid = rect_valid_q;
    assign in_rect    = in_rect_q;
    assign rect_count = rect_count_q;

endmodule
